// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the iterative multiplier/divider
package multdiv_pkg;

    localparam int WIDTH = 32;
    localparam logic [WIDTH-1:0] MIN_INT = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

endpackage

// File: rtl/multdiv_iter_if.sv
// rtl/multdiv_iter_if.sv - start/operand/result bundle between the execute stage and multdiv_iter
// master: execute stage (drives start pulses and operands, receives result/flags)
// slave : multdiv_iter
interface multdiv_iter_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/reduce_all_ones.sv
// rtl/reduce_all_ones.sv - WIDTH-wide AND reduction as a tree of 8-input AND cells
// in_i  : vector to reduce (WIDTH must be a multiple of 8)
// all_o : 1 when every bit of in_i is 1
module reduce_all_ones #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_i,
    output logic             all_o
);
    localparam int CELLS = WIDTH / 8;

    logic [CELLS-1:0] cell_and;

    for (genvar g = 0; g < CELLS; g++) begin : g_cell
        assign cell_and[g] = &in_i[g*8 +: 8];
    end

    // Second tree level; a single 8-input cell for widths up to 64.
    assign all_o = &cell_and;
endmodule

// File: rtl/multdiv_iter.sv
// rtl/multdiv_iter.sv - iterative signed 32-bit multiplier / restoring divider
// clock   : rising-edge clock
// reset_n : asynchronous active-low reset
// bus     : slave side of multdiv_iter_if (start pulses, operands, result, exception, RDY, busy)
module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = multdiv_pkg::WIDTH,
    parameter int CNT_W = 6
) (
    input logic          clock,
    input logic          reset_n,
    multdiv_iter_if.slave bus
);
    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   a_q, a_d;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   hi_q, hi_d;    // product high half or partial remainder
    logic [WIDTH-1:0]   lo_q, lo_d;    // multiplier/product low half or dividend/quotient
    logic [WIDTH-1:0]   res_q, res_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;

    logic               start;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               b_zero, b_minus1, a_min;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_mag, prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic               hi_ones, hi_zeros, mul_exc;

    assign start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign abs_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign abs_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
    assign a_min = (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}});

    reduce_all_ones #(.WIDTH(WIDTH)) u_b_zero   (.in_i(~bus.data_operandB), .all_o(b_zero));
    reduce_all_ones #(.WIDTH(WIDTH)) u_b_minus1 (.in_i(bus.data_operandB),  .all_o(b_minus1));

    // One shift-add step: add multiplicand when the current multiplier bit is set, shift right.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    // One restoring-divide step: bring in next dividend bit, trial-subtract divisor.
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, a_q};

    assign prod_mag = {hi_q, lo_q};
    assign prod_s   = neg_q ? -prod_mag : prod_mag;
    assign quo_s    = neg_q ? -lo_q : lo_q;

    // Product fits in WIDTH signed bits iff the top WIDTH+1 bits are all equal.
    reduce_all_ones #(.WIDTH(WIDTH)) u_hi_ones  (.in_i(prod_s[2*WIDTH-1:WIDTH]),  .all_o(hi_ones));
    reduce_all_ones #(.WIDTH(WIDTH)) u_hi_zeros (.in_i(~prod_s[2*WIDTH-1:WIDTH]), .all_o(hi_zeros));
    assign mul_exc = ~((hi_ones & prod_s[WIDTH-1]) | (hi_zeros & ~prod_s[WIDTH-1]));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        a_d     = a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        exc_d   = exc_q;
        rdy_d   = 1'b0;

        if (start) begin
            // A start in any state (re)launches; an aborted op never reaches its RDY.
            cnt_d = '0;
            hi_d  = '0;
            exc_d = 1'b0;
            neg_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            if (bus.ctrl_MULT) begin
                op_d    = OP_MULT;
                a_d     = abs_a;
                lo_d    = abs_b;
                ovf_d   = 1'b0;
                dz_d    = 1'b0;
                state_d = RUN;
            end else begin
                op_d    = OP_DIV;
                a_d     = abs_b;
                lo_d    = abs_a;
                ovf_d   = a_min & b_minus1;
                dz_d    = b_zero;
                state_d = b_zero ? DONE : RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (op_q == OP_MULT) begin
                        hi_d = mul_sum[WIDTH:1];
                        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                    end else if (!div_diff[WIDTH]) begin
                        hi_d = div_diff[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Sign fix-up and flagging happen here so RDY comes from a register.
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                    if (op_q == OP_MULT) begin
                        res_d = prod_s[WIDTH-1:0];
                        exc_d = mul_exc;
                    end else begin
                        res_d = dz_q ? '0 : quo_s;
                        exc_d = dz_q | ovf_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.data_result    = res_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_multdiv_iter.sv
// tb/tb_multdiv_iter.sv - self-checking bench for multdiv_iter
module tb_multdiv_iter;
    import multdiv_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    multdiv_iter_if #(.WIDTH(32)) bus ();

    multdiv_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers.
    task automatic model(input bit m, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e);
        longint p;
        int     ia, ib;
        ia = a;
        ib = b;
        if (m) begin
            p = longint'(ia) * longint'(ib);
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == MIN_INT && b == 32'hFFFF_FFFF) begin
            r = MIN_INT;
            e = 1'b1;
        end else begin
            r = ia / ib;
            e = 1'b0;
        end
    endtask

    task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic exp_e, input int exp_lat,
                         input string tag);
        int lat;
        int bc;
        lat = 0;
        @(negedge clock);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        check({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
        check({tag, "_exc_clr"}, 32'(bus.data_exception), 32'd0);
        bc = bus.busy ? 1 : 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY) begin
                lat = k;
                break;
            end
            if (bus.busy) bc++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_lat));
        check({tag, "_result"}, bus.data_result, exp_r);
        check({tag, "_exc"}, 32'(bus.data_exception), 32'(exp_e));
        check({tag, "_busy_at_rdy"}, 32'(bus.busy), 32'd0);
        @(posedge clock);
        #1;
        check({tag, "_rdy_pulse"}, 32'(bus.data_resultRDY), 32'd0);
        check({tag, "_result_hold"}, bus.data_result, exp_r);
    endtask

    initial begin
        logic [31:0] ra, rb, er;
        logic        ee;
        bit          rm;
        int          rdy_seen;

        reset_n           = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (2) @(posedge clock);
        bus.ctrl_MULT = 1'b1;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        check("rst_result", bus.data_result, 32'd0);
        check("rst_exc", 32'(bus.data_exception), 32'd0);
        check("rst_rdy", 32'(bus.data_resultRDY), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        do_op(1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33, "mul_7x-3");
        do_op(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 33, "mul_ovf");
        do_op(1, 0, 32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 1'b0, 33, "mul_minint");
        do_op(0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, "div_-7/2");
        do_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33, "div_min/-1");
        do_op(0, 1, 32'd123, 32'd0, 32'd0, 1'b1, 1, "div_by_zero");

        // Abort a divide ten cycles in with a multiply; only the multiply may report.
        @(negedge clock);
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = 32'd100;
        bus.data_operandB = 32'd7;
        @(posedge clock);
        #1;
        bus.ctrl_DIV = 1'b0;
        rdy_seen = 0;
        repeat (9) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY) rdy_seen++;
        end
        check("abort_no_early_rdy", 32'(rdy_seen), 32'd0);
        do_op(1, 0, 32'd5, 32'd6, 32'd30, 1'b0, 33, "restart_mul");

        do_op(1, 1, 32'd6, 32'd3, 32'd18, 1'b0, 33, "both_start");

        // Reset in the middle of a multiply.
        @(negedge clock);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd9;
        bus.data_operandB = 32'd9;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midrst_result", bus.data_result, 32'd0);
        check("midrst_exc", 32'(bus.data_exception), 32'd0);
        check("midrst_rdy", 32'(bus.data_resultRDY), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        rdy_seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY) rdy_seen++;
        end
        check("midrst_no_rdy", 32'(rdy_seen), 32'd0);
        check("midrst_idle", 32'(bus.busy), 32'd0);

        // Randomized operations against the arithmetic reference.
        for (int i = 0; i < 12; i++) begin
            rm = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                ra = $urandom;
                rb = $urandom;
            end else begin
                ra = $urandom_range(0, 5000);
                rb = $urandom_range(0, 300);
                if ($urandom_range(0, 1) == 1) ra = -ra;
                if ($urandom_range(0, 1) == 1) rb = -rb;
            end
            if (!rm && $urandom_range(0, 5) == 0) rb = 32'd0;
            model(rm, ra, rb, er, ee);
            do_op(rm, !rm, ra, rb, er, ee, (!rm && rb == 32'd0) ? 1 : 33,
                  $sformatf("rand%0d_%s", i, rm ? "mul" : "div"));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
